// File: rtl/line_decoder_arbiter_if.sv
// Request/decoder-drive bundle shared by the arbiter and whoever sits around it.
// Latency: pure wiring, no storage.
// Backpressure: none; req is level-sensitive and only sampled in IDLE/GRANT.
// Ports: req[7:0] (requesters -> arbiter); enable, a, b, c, grant[7:0], busy
//        (arbiter -> decoder/local logic).
interface line_decoder_arbiter_if;
  logic [7:0] req;
  logic       enable;
  logic       a;
  logic       b;
  logic       c;
  logic [7:0] grant;
  logic       busy;

  // master: the arbiter itself
  modport master (
    input  req,
    output enable, a, b, c, grant, busy
  );

  // slave: requesters and the downstream 3-to-8 decoder
  modport slave (
    output req,
    input  enable, a, b, c, grant, busy
  );
endinterface

// File: rtl/line_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 line decoder among 8 requesters.
// Latency: req high before edge k -> enable/grant high after edge k; grants last 1..MAX_HOLD cycles.
// Backpressure: none; losers simply keep req high and wait their round-robin turn.
// Ports: clk, rst (async, active-high); io.master: req[7:0] in; enable, a/b/c
//        (decoder select, {a,b,c} = ~winner), grant[7:0] one-hot, busy out.
module line_decoder_arbiter #(
  parameter int MAX_HOLD   = 4,  // 1..255
  parameter int GAP_CYCLES = 1   // 0..15
) (
  input logic                 clk,
  input logic                 rst,
  line_decoder_arbiter_if.master io
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [3:0] GAP_LIM  = 4'(GAP_CYCLES);
  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] win, win_n;
  logic [7:0] hold_cnt, hold_n;
  logic [3:0] gap_cnt, gap_n;
  logic       enable_q, enable_n;
  logic [2:0] abc_q, abc_n;
  logic [7:0] grant_q, grant_n;
  logic       busy_q, busy_n;

  // Round-robin pick: rotate req so that bit 0 is the requester at ptr,
  // find the lowest set bit, then rotate the offset back.
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  rr_off;
  logic [2:0]  rr_win;

  always_comb begin
    req_dbl = {io.req, io.req};
    req_rot = req_dbl[ptr +: 8];
    rr_off  = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (req_rot[j]) rr_off = j[2:0];
    end
    rr_win = ptr + rr_off;
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    win_n    = win;
    hold_n   = hold_cnt;
    gap_n    = gap_cnt;
    enable_n = enable_q;
    abc_n    = abc_q;      // select lines only move on a new grant
    grant_n  = grant_q;
    busy_n   = busy_q;

    unique case (state)
      IDLE: begin
        if (io.req != 8'd0) begin
          state_n  = GRANT;
          win_n    = rr_win;
          hold_n   = 8'd1;
          enable_n = 1'b1;
          abc_n    = ~rr_win;
          grant_n  = 8'b1 << rr_win;
          busy_n   = 1'b1;
        end
      end

      GRANT: begin
        // A winner dropping req on the MAX_HOLD cycle is still one release.
        if (!io.req[win] || hold_cnt == HOLD_LIM) begin
          enable_n = 1'b0;
          grant_n  = 8'd0;
          ptr_n    = win + 3'd1;
          if (HAS_GAP) begin
            state_n = GAP;
            gap_n   = 4'd1;
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LIM) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          gap_n = gap_cnt + 4'd1;
        end
      end

      default: begin
        state_n  = IDLE;
        enable_n = 1'b0;
        grant_n  = 8'd0;
        busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      win      <= 3'd0;
      hold_cnt <= 8'd0;
      gap_cnt  <= 4'd0;
      enable_q <= 1'b0;
      abc_q    <= 3'd0;
      grant_q  <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      win      <= win_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      enable_q <= enable_n;
      abc_q    <= abc_n;
      grant_q  <= grant_n;
      busy_q   <= busy_n;
    end
  end

  assign io.enable = enable_q;
  assign io.a      = abc_q[2];
  assign io.b      = abc_q[1];
  assign io.c      = abc_q[0];
  assign io.grant  = grant_q;
  assign io.busy   = busy_q;

endmodule

// File: tb/tb_line_decoder_arbiter.sv
// Bench for line_decoder_arbiter: two instances (MAX_HOLD=4/GAP=1 and MAX_HOLD=2/GAP=0)
// driven by directed steps then random req, compared each cycle to a reference model.
module tb_line_decoder_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  line_decoder_arbiter_if if0 ();
  line_decoder_arbiter_if if1 ();

  line_decoder_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .io(if0.master));
  line_decoder_arbiter #(.MAX_HOLD(2), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .io(if1.master));

  // Reference model: current winner (-1 = none), cycles granted so far,
  // gap cycles elapsed (0 = not in a gap), next round-robin start, last select.
  int         mh [2] = '{4, 2};
  int         gp [2] = '{1, 0};
  int         m_win [2];
  int         m_hold [2];
  int         m_gap [2];
  int         m_ptr [2];
  logic [2:0] m_abc [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_win[k] = -1; m_hold[k] = 0; m_gap[k] = 0; m_ptr[k] = 0; m_abc[k] = 3'd0;
    end
  endtask

  task automatic model_step(input int k, input logic [7:0] r);
    bit found;
    if (m_win[k] >= 0) begin
      if (!r[m_win[k]] || m_hold[k] == mh[k]) begin
        m_ptr[k] = (m_win[k] + 1) % 8;
        m_win[k] = -1;
        m_gap[k] = (gp[k] > 0) ? 1 : 0;
      end else begin
        m_hold[k]++;
      end
    end else if (m_gap[k] > 0) begin
      if (m_gap[k] == gp[k]) m_gap[k] = 0;
      else m_gap[k]++;
    end else if (r != 8'd0) begin
      found = 0;
      for (int n = 0; n < 8; n++) begin
        if (!found && r[(m_ptr[k] + n) % 8]) begin
          m_win[k] = (m_ptr[k] + n) % 8;
          found = 1;
        end
      end
      m_hold[k] = 1;
      m_abc[k]  = 3'(7 - m_win[k]);
    end
  endtask

  // Packed view: {busy, enable, a, b, c, grant}
  function automatic logic [12:0] observed(input int k);
    if (k == 0) return {if0.busy, if0.enable, if0.a, if0.b, if0.c, if0.grant};
    return {if1.busy, if1.enable, if1.a, if1.b, if1.c, if1.grant};
  endfunction

  function automatic logic [12:0] expected(input int k);
    logic       en;
    logic [7:0] g;
    en = (m_win[k] >= 0);
    g  = en ? 8'(1 << m_win[k]) : 8'd0;
    return {(en || m_gap[k] > 0), en, m_abc[k], g};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive req for one cycle, advance the model on the edge, compare just after it.
  task automatic cycle(input logic [7:0] r0, input logic [7:0] r1);
    if0.req = r0;
    if1.req = r1;
    @(posedge clk);
    model_step(0, r0);
    model_step(1, r1);
    #1;
    chk("inst0_outputs", 16'(observed(0)), 16'(expected(0)));
    chk("inst1_outputs", 16'(observed(1)), 16'(expected(1)));
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    if0.req = 8'd0;
    if1.req = 8'd0;
    #1;
    chk("async_rst_inst0", 16'(observed(0)), 16'd0);
    chk("async_rst_inst1", 16'(observed(1)), 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Structural invariants, every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        logic [12:0] o;
        logic [7:0]  g;
        logic [2:0]  sel;
        logic        ok;
        o   = observed(k);
        g   = o[7:0];
        sel = o[10:8];
        ok  = ((g & (g - 8'd1)) == 8'd0) && ((g != 8'd0) == o[11]);
        if (o[11]) ok = ok && (g == 8'(1 << (7 - int'(sel))));
        chk(k == 0 ? "invariant_inst0" : "invariant_inst1", 16'(ok), 16'd1);
      end
    end
  end

  initial begin
    logic [7:0] r0, r1;
    rst = 1'b1;
    if0.req = 8'd0;
    if1.req = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_inst0", 16'(observed(0)), 16'd0);
    chk("reset_inst1", 16'(observed(1)), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester on inst0 (4-cycle grants, gap); full contention on inst1.
    repeat (20) cycle(8'h08, 8'hFF);

    // Reset in the middle of a grant to requester 5, then regrant from ptr 0.
    do_reset();
    cycle(8'h20, 8'h00);
    cycle(8'h20, 8'h00);
    chk("grant5_live", 16'(if0.grant), 16'h0020);
    do_reset();
    cycle(8'h20, 8'h00);
    chk("post_rst_abc", 16'({if0.a, if0.b, if0.c}), 16'b010);
    chk("post_rst_grant", 16'(if0.grant), 16'h0020);

    // Early release after 2 cycles, then requester 7 wins before 0.
    do_reset();
    cycle(8'h01, 8'h03);
    cycle(8'h01, 8'h03);
    cycle(8'h00, 8'h03);
    cycle(8'h00, 8'h03);
    cycle(8'h00, 8'h03);
    cycle(8'h81, 8'h03);
    chk("rr_after_early_rel", 16'({if0.a, if0.b, if0.c, if0.grant}), {5'd0, 3'b000, 8'h80});
    repeat (6) cycle(8'h81, 8'h03);

    // Wrap and skip: ptr=6 after grant to 5; req 05 -> winner 0 then 2.
    do_reset();
    cycle(8'h20, 8'h03);
    cycle(8'h00, 8'h03);
    cycle(8'h05, 8'h03);
    cycle(8'h05, 8'h03);
    chk("wrap_to_0", 16'(if0.grant), 16'h0001);
    repeat (10) cycle(8'h05, 8'h03);

    // Random req with occasional changes and sparse patterns, one mid-run reset.
    r0 = 8'd0;
    r1 = 8'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r1 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r0 = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r1 = r1 & ~8'(1 << $urandom_range(0, 7));
      cycle(r0, r1);
      if (i == 700) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
